// File: rtl/mul_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : mul_arb2 (with local shared multiplier mul)
//  Brief    : Round-robin sequencer sharing one 8x8 combinational multiplier
//             between two valid/ready requesters, with an id-tagged,
//             backpressured product output and a completed-transaction counter.
//  Revision : 1.0 - initial release
// ============================================================================

module mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] y
);

  assign y = {8'd0, a} * {8'd0, b};

endmodule

module mul_arb2 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid0,
  input  logic [7:0]       a0,
  input  logic [7:0]       b0,
  output logic             ready0,
  input  logic             valid1,
  input  logic [7:0]       a1,
  input  logic [7:0]       b1,
  output logic             ready1,
  output logic             out_valid,
  output logic [15:0]      out_y,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic             r_id;
  logic             r_last_id;

  logic [15:0]      r_out_y;
  logic             r_out_id;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_txn_cnt;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_out_hs;
  logic [15:0]      w_prod;

  // The multiplier only ever sees the latched operands, never live inputs.
  mul u_mul (
    .a (r_a),
    .b (r_b),
    .y (w_prod)
  );

  // Round-robin: on contention the requester that did not win last time wins.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant0 = valid0 & (~valid1 | r_last_id);
      w_grant1 = valid1 & (~valid0 | ~r_last_id);
    end
  end

  assign w_accept = w_grant0 | w_grant1;
  assign w_out_hs = (r_state == S_HOLD) & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MUL;
      S_MUL:   w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready0 = w_grant0;
    ready1 = w_grant1;
    busy   = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= 8'd0;
      r_b       <= 8'd0;
      r_id      <= 1'b0;
      r_last_id <= 1'b1;
    end else if (w_accept) begin
      r_a       <= w_grant1 ? a1 : a0;
      r_b       <= w_grant1 ? b1 : b0;
      r_id      <= w_grant1;
      r_last_id <= w_grant1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_y     <= 16'd0;
      r_out_id    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (r_state == S_MUL) begin
      r_out_y     <= w_prod;
      r_out_id    <= r_id;
      r_out_valid <= 1'b1;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  // Counts consumer handshakes only; out_ready outside HOLD is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_cnt <= '0;
    end else if (w_out_hs) begin
      r_txn_cnt <= r_txn_cnt + c_cnt_one;
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign out_id    = r_out_id;
  assign txn_cnt   = r_txn_cnt;

endmodule

`default_nettype wire
